// File: rtl/seq_serializer_pkg.sv
// rtl/seq_serializer_pkg.sv - shared state encoding and defaults for the serializer
package seq_serializer_pkg;

    // Two-state serializer FSM, encoding fixed so detector FSMs can share it
    typedef enum logic {
        SER_IDLE  = 1'b0,
        SER_SHIFT = 1'b1
    } ser_state_t;

    localparam int SER_DEFAULT_WIDTH = 16;

endpackage

// File: rtl/seq_bit_counter.sv
// rtl/seq_bit_counter.sv - bit position up-counter with clear, enable and terminal flag
module seq_bit_counter #(
    parameter int WIDTH = 16,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [CW-1:0] cnt;

    // Count consumed bits; clear has priority so a reload always restarts at 0
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = (cnt == CW'(WIDTH - 1));

endmodule

// File: rtl/seq_serializer.sv
// rtl/seq_serializer.sv - parallel-to-serial bit source with valid/ready input and stall
module seq_serializer
    import seq_serializer_pkg::*;
#(
    parameter int WIDTH     = SER_DEFAULT_WIDTH,
    parameter int MSB_FIRST = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             out_en,
    output logic             out_bit,
    output logic             out_valid,
    output logic             last_bit,
    output logic             word_done
);

    ser_state_t       state;
    ser_state_t       next_state;
    logic [WIDTH-1:0] shreg;
    logic             tc;
    logic             accept;
    logic             final_take;
    logic             cnt_clr;
    logic             cnt_en;

    // The counter also clears when the final bit leaves, so it never wraps on its own
    seq_bit_counter #(
        .WIDTH (WIDTH)
    ) u_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .en  (cnt_en),
        .tc  (tc)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SER_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state and handshake; in_ready reopens on the final consumed bit for gapless chaining
    always_comb begin
        next_state = state;
        out_valid  = 1'b0;
        last_bit   = 1'b0;
        final_take = 1'b0;
        in_ready   = 1'b0;
        accept     = 1'b0;
        cnt_en     = 1'b0;
        cnt_clr    = 1'b0;
        case (state)
            SER_IDLE: begin
                in_ready = 1'b1;
                accept   = in_valid;
                if (in_valid) begin
                    next_state = SER_SHIFT;
                end
            end
            SER_SHIFT: begin
                out_valid  = 1'b1;
                last_bit   = tc;
                final_take = tc && out_en;
                in_ready   = final_take;
                accept     = final_take && in_valid;
                cnt_en     = out_en;
                if (final_take && !in_valid) begin
                    next_state = SER_IDLE;
                end
            end
            default: next_state = SER_IDLE;
        endcase
        cnt_clr = accept || final_take;
    end

    // Shift register: load on accept, move one bit toward the emit end per consumed bit
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg <= '0;
        end else if (accept) begin
            shreg <= in_data;
        end else if (out_valid && out_en) begin
            if (MSB_FIRST != 0) begin
                shreg <= {shreg[WIDTH-2:0], 1'b0};
            end else begin
                shreg <= {1'b0, shreg[WIDTH-1:1]};
            end
        end
    end

    // One-cycle completion pulse after the final bit is consumed
    always_ff @(posedge clk) begin
        if (rst) begin
            word_done <= 1'b0;
        end else begin
            word_done <= final_take;
        end
    end

    assign out_bit = (MSB_FIRST != 0) ? shreg[WIDTH-1] : shreg[0];

endmodule
